slow_ch_tx: RTL

Transmit side of the 6 MB/s Cray slow-channel model; this is the stage that feeds a slow-channel receiver over the external channel.
- Accepts 64-bit words from the internal (DMA/CPU) side into a 2-entry buffer.
- Serializes each word into four 16-bit halfwords, least-significant first, matching receiver reassembly order.
- Asserts disconnect on the final halfword of a transfer and raises a completion pulse.

---
 rtl/slow_ch_pkg.sv | 30 +++
 rtl/slow_ch_tx_fifo.sv | 58 +++++
 rtl/slow_ch_tx.sv | 90 +++++++++
 3 files changed

// File: rtl/slow_ch_pkg.sv
// Shared types and constants for the Cray slow-channel model.
// Used by both the transmit and receive sides of the channel.
package slow_ch_pkg;

   localparam int HW_W           = 16;
   localparam int WORD_W         = 64;
   localparam int BEATS_PER_WORD = 4;
   localparam int PTR_W          = 2;

   typedef struct packed {
      logic              last;
      logic [WORD_W-1:0] data;
   } ch_word_t;

   // Halfword ptr of a word, least-significant halfword first.
   function automatic logic [HW_W-1:0] hw_sel(
      input logic [WORD_W-1:0] w,
      input logic [PTR_W-1:0]  p
   );
      logic [HW_W-1:0] r;
      unique case (p)
         2'd0: r = w[15:0];
         2'd1: r = w[31:16];
         2'd2: r = w[47:32];
         2'd3: r = w[63:48];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/slow_ch_tx_fifo.sv
// Two-entry word buffer between the internal side and the serializer.
// Writes are gated only by full; the head entry is always visible.
module slow_ch_tx_fifo
   import slow_ch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_i,
   input  logic       rd_i,
   input  ch_word_t   din_i,
   output ch_word_t   head_o,
   output logic [1:0] count_o,
   output logic       full_o
);

   ch_word_t   mem_q [2];
   logic       wp_q;
   logic       rp_q;
   logic [1:0] cnt_q;
   logic [1:0] cnt_d;
   logic       wr_en;
   logic       rd_en;

   assign full_o  = (cnt_q == 2'd2);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rp_q];
   assign wr_en   = wr_i && !full_o;
   assign rd_en   = rd_i && (cnt_q != 2'd0);

   // Occupancy follows accepted writes and pops.
   always_comb begin
      cnt_d = cnt_q;
      unique case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage needs no reset; occupancy decides validity.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wp_q] <= din_i;
   end

   // Pointers and count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= 1'b0;
         rp_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         if (wr_en) wp_q <= ~wp_q;
         if (rd_en) rp_q <= ~rp_q;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/slow_ch_tx.sv
// Slow-channel transmitter: buffers 64-bit words and sends them as
// four paced 16-bit beats, flagging disconnect on the final beat.
module slow_ch_tx
   import slow_ch_pkg::*;
#(
   parameter int PACE_CYCLES = 0,
   parameter int GAP_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] i_data,
   input  logic              i_wr,
   input  logic              i_last,
   output logic              o_full,
   output logic              o_busy,
   output logic              o_int,
   output logic [HW_W-1:0]   p_channel_data,
   output logic              p_channel_srdy,
   input  logic              p_channel_drdy,
   output logic              p_channel_disconnect,
   output logic              p_channel_data_valid
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BEATS_PER_WORD - 1);
   localparam logic [GAP_W-1:0] GAP_LD   = GAP_W'(PACE_CYCLES);

   ch_word_t         head;
   ch_word_t         din;
   logic [1:0]       cnt;
   logic             full;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             int_q, int_d;
   logic             srdy;
   logic             beat;
   logic             at_end;
   logic             pop;

   assign din    = '{last: i_last, data: i_data};
   assign srdy   = (cnt != 2'd0) && (gap_q == '0);
   assign beat   = srdy && p_channel_drdy;
   assign at_end = (ptr_q == LAST_PTR);
   assign pop    = beat && at_end;

   slow_ch_tx_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (i_wr),
      .rd_i    (pop),
      .din_i   (din),
      .head_o  (head),
      .count_o (cnt),
      .full_o  (full)
   );

   assign o_full               = full;
   assign o_busy               = (cnt != 2'd0);
   assign o_int                = int_q;
   assign p_channel_srdy       = srdy;
   assign p_channel_data_valid = srdy;
   assign p_channel_data       = srdy ? hw_sel(head.data, ptr_q) : '0;
   assign p_channel_disconnect = srdy && at_end && head.last;

   // Next beat pointer, pacing gap and completion pulse.
   always_comb begin
      ptr_d = ptr_q;
      gap_d = gap_q;
      int_d = beat && at_end && head.last;
      if (beat) begin
         ptr_d = ptr_q + PTR_W'(1);
         gap_d = GAP_LD;
      end else if (gap_q != '0) begin
         gap_d = gap_q - GAP_W'(1);
      end
   end

   // Serializer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
         gap_q <= '0;
         int_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         gap_q <= gap_d;
         int_q <= int_d;
      end
   end

endmodule
